// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion, hold/flush handling
// and hold-time operand refresh. Define ID_EX_WB_BYPASS_EN to bypass same-cycle writeback data at load.
module id_ex_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [9:0]       id_ctrl,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [9:0]       ex_ctrl,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int unsigned MEM_RD_BIT = 7;

  logic             ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  logic [4:0]       ex_rs1_q, ex_rs1_d;
  logic [4:0]       ex_rs2_q, ex_rs2_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic [XLEN-1:0]  ex_op1_q, ex_op1_d;
  logic [XLEN-1:0]  ex_op2_q, ex_op2_d;
  logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
  logic [9:0]       ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic            haz;
  logic [XLEN-1:0] op1_ld, op2_ld;

  assign haz = ex_valid_q & ex_ctrl_q[MEM_RD_BIT] & id_valid & (ex_rd_q != '0)
             & ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
  assign stall_o = (haz | hold_i) & ~flush_i;

  always_comb begin
`ifdef ID_EX_WB_BYPASS_EN
    op1_ld = (wb_we && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_data : id_rd1;
    op2_ld = (wb_we && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_data : id_rd2;
`else
    op1_ld = id_rd1;
    op2_ld = id_rd2;
`endif
  end

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_rd_d      = ex_rd_q;
    ex_op1_d     = ex_op1_q;
    ex_op2_d     = ex_op2_q;
    ex_imm_d     = ex_imm_q;
    ex_ctrl_d    = ex_ctrl_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i || (!hold_i && !haz)) begin
      ex_valid_d = id_valid;
      ex_pc_d    = id_pc;
      ex_rs1_d   = id_rs1;
      ex_rs2_d   = id_rs2;
      ex_rd_d    = id_rd;
      ex_op1_d   = op1_ld;
      ex_op2_d   = op2_ld;
      ex_imm_d   = id_imm;
      ex_ctrl_d  = id_ctrl;
      // flush loads the datapath fields but kills the instruction
      if (flush_i) begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
      end
    end else if (hold_i) begin
      if (wb_we && (wb_rd != '0) && (wb_rd == ex_rs1_q)) ex_op1_d = wb_data;
      if (wb_we && (wb_rd != '0) && (wb_rd == ex_rs2_q)) ex_op2_d = wb_data;
    end else begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_rd_q      <= '0;
      ex_op1_q     <= '0;
      ex_op2_q     <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_rd_q      <= ex_rd_d;
      ex_op1_q     <= ex_op1_d;
      ex_op2_q     <= ex_op2_d;
      ex_imm_q     <= ex_imm_d;
      ex_ctrl_q    <= ex_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rs1     = ex_rs1_q;
  assign ex_rs2     = ex_rs2_q;
  assign ex_rd      = ex_rd_q;
  assign ex_op1     = ex_op1_q;
  assign ex_op2     = ex_op2_q;
  assign ex_imm     = ex_imm_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
